// File: rtl/wb_bram_slave_if.sv
// Wishbone B3 slave-side signal bundle for wb_bram_slave; clock and reset stay outside.
interface wb_bram_slave_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic [2:0]  wb_cti_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cti_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_cti_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_bram_slave.sv
// Wishbone slave wrapping a 2**adr_width x 32 synchronous block RAM with byte-lane writes.
// Define BRAM_BURST_EN to build the BURST state (single-cycle beats for CTI incrementing bursts).
module wb_bram_slave #(
    parameter int unsigned adr_width = 11
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    wb_bram_slave_if.slave   wb
);

    localparam int unsigned DEPTH    = 2 ** adr_width;
    localparam logic [2:0]  CTI_INCR = 3'b010;

`ifdef BRAM_BURST_EN
    typedef enum logic [1:0] {IDLE, ACK, BURST} state_e;
`else
    typedef enum logic [1:0] {IDLE, ACK} state_e;
`endif

    state_e                 state_q, state_d;
    logic                   ack_q, ack_d;
    logic                   req_c;
    logic                   wr_en_c;
    logic [adr_width-1:0]   word_c;
    logic [adr_width-1:0]   rd_adr_c;
    logic [31:0]            rd_word;

    assign req_c   = wb.wb_cyc_i & wb.wb_stb_i;
    assign word_c  = wb.wb_adr_i[adr_width+1:2];
    assign wr_en_c = wb.wb_ack_o & wb.wb_we_i & ~sys_rst;

    assign wb.wb_ack_o = ack_q & req_c;
    assign wb.wb_dat_o = rd_word;

    // Upper address bits alias; byte offset is implied by sel.
`ifdef BRAM_BURST_EN
    logic unused_bits;
    assign unused_bits = ^{wb.wb_adr_i[31:adr_width+2], wb.wb_adr_i[1:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{wb.wb_adr_i[31:adr_width+2], wb.wb_adr_i[1:0], wb.wb_cti_i};
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    // Next state and RAM read address; BURST prefetches the following word.
    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        rd_adr_c = word_c;
        case (state_q)
            IDLE: begin
                if (req_c) begin
                    ack_d   = 1'b1;
                    state_d = ACK;
`ifdef BRAM_BURST_EN
                    if (wb.wb_cti_i == CTI_INCR) begin
                        state_d = BURST;
                    end
`endif
                end
            end
            ACK: begin
                state_d = IDLE;
            end
`ifdef BRAM_BURST_EN
            BURST: begin
                rd_adr_c = word_c + adr_width'(1);
                if (req_c && (wb.wb_cti_i == CTI_INCR)) begin
                    ack_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // One RAM per byte lane so each lane has a single writer.
    for (genvar b = 0; b < 4; b++) begin : g_lane
        logic [7:0] lane_q [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge sys_clk) begin
            if (wr_en_c && wb.wb_sel_i[b]) begin
                lane_q[word_c] <= wb.wb_dat_i[8*b +: 8];
            end
        end

        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                rd_q <= 8'h00;
            end else if (req_c) begin
                rd_q <= lane_q[rd_adr_c];
            end
        end

        assign rd_word[8*b +: 8] = rd_q;
    end

endmodule
